// File: rtl/nco_mixer_decim.sv
// rtl/nco_mixer_decim.sv - complex mixer with integrate-and-dump decimator and valid/ready output
// Optional feature macro: MIXER_DECIM_ROUND_EN (round half up before the right shift)
module nco_mixer_decim #(
    parameter int DW   = 12,
    parameter int IW   = 12,
    parameter int DECW = 12,
    parameter int OW   = 16,
    parameter int ACCW = DW + IW + DECW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic signed [DW-1:0]   i_sample,
    input  logic signed [IW-1:0]   i_cos,
    input  logic signed [IW-1:0]   i_sin,
    input  logic [DECW-1:0]        i_decim_m1,
    input  logic [5:0]             i_shift,
    input  logic                   i_flag_clr,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic signed [OW-1:0]   o_i,
    output logic signed [OW-1:0]   o_q,
    output logic                   o_sat,
    output logic                   o_ovr
);

    localparam int PW = DW + IW;
    localparam logic signed [ACCW:0] LIM_HI = {{(ACCW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW:0] LIM_LO = ~LIM_HI;

    // Scale one frame sum: optional rounding, arithmetic shift, clamp. Returns {clamped, y}.
    function automatic logic [OW:0] scale(input logic signed [ACCW-1:0] s, input logic [5:0] sh);
        logic signed [ACCW:0] v;
        v = {s[ACCW-1], s};
`ifdef MIXER_DECIM_ROUND_EN
        if (sh != 6'd0) begin
            v = v + ((ACCW+1)'(1) <<< (sh - 6'd1));
        end
`endif
        v = v >>> sh;
        if (v > LIM_HI) begin
            return {1'b1, LIM_HI[OW-1:0]};
        end else if (v < LIM_LO) begin
            return {1'b1, LIM_LO[OW-1:0]};
        end
        return {1'b0, v[OW-1:0]};
    endfunction

    logic signed [PW-1:0]   w_x, w_c, w_s, w_mul_i, w_mul_q;
    logic signed [PW-1:0]   r_p_i, r_p_q;
    logic                   r_p_vld;

    logic [DECW-1:0]        r_cnt, r_len;
    logic signed [ACCW-1:0] r_acc_i, r_acc_q, r_sum_i, r_sum_q;
    logic                   r_s_vld;
    logic signed [ACCW-1:0] w_p_i_ext, w_p_q_ext, w_sum_i, w_sum_q;
    logic [DECW-1:0]        w_len;
    logic                   w_first, w_last;

    logic [OW:0]            w_sc_i, w_sc_q;
    logic signed [OW-1:0]   r_y_i, r_y_q;
    logic                   r_y_vld;

    // Operands widened to product width so the multiply is full precision.
    assign w_x     = {{IW{i_sample[DW-1]}}, i_sample};
    assign w_c     = {{DW{i_cos[IW-1]}}, i_cos};
    assign w_s     = {{DW{i_sin[IW-1]}}, i_sin};
    assign w_mul_i = w_x * w_c;
    assign w_mul_q = w_x * w_s;

    // Stage 1: register I = x*cos and Q = -x*sin with a valid tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_vld <= 1'b0;
            r_p_i   <= '0;
            r_p_q   <= '0;
        end else begin
            r_p_vld <= ce;
            if (ce) begin
                r_p_i <= w_mul_i;
                r_p_q <= -w_mul_q;
            end
        end
    end

    // The frame length is taken live from the input on the first product and held after that.
    assign w_p_i_ext = {{(ACCW-PW){r_p_i[PW-1]}}, r_p_i};
    assign w_p_q_ext = {{(ACCW-PW){r_p_q[PW-1]}}, r_p_q};
    assign w_first   = (r_cnt == '0);
    assign w_len     = w_first ? i_decim_m1 : r_len;
    assign w_last    = (r_cnt == w_len);
    assign w_sum_i   = w_first ? w_p_i_ext : r_acc_i + w_p_i_ext;
    assign w_sum_q   = w_first ? w_p_q_ext : r_acc_q + w_p_q_ext;

    // Stage 2: integrate tagged products and dump the sum on the last one of a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_len   <= '0;
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_sum_i <= '0;
            r_sum_q <= '0;
            r_s_vld <= 1'b0;
        end else begin
            r_s_vld <= r_p_vld && w_last;
            if (r_p_vld) begin
                r_acc_i <= w_sum_i;
                r_acc_q <= w_sum_q;
                if (w_first) begin
                    r_len <= i_decim_m1;
                end
                if (w_last) begin
                    r_sum_i <= w_sum_i;
                    r_sum_q <= w_sum_q;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DECW'(1);
                end
            end
        end
    end

    assign w_sc_i = scale(r_sum_i, i_shift);
    assign w_sc_q = scale(r_sum_q, i_shift);

    // Stage 3: register scaled pair; a clamp sets the sticky flag, which wins over a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y_vld <= 1'b0;
            r_y_i   <= '0;
            r_y_q   <= '0;
            o_sat   <= 1'b0;
        end else begin
            r_y_vld <= r_s_vld;
            if (r_s_vld) begin
                r_y_i <= w_sc_i[OW-1:0];
                r_y_q <= w_sc_q[OW-1:0];
            end
            o_sat <= (o_sat && !i_flag_clr) || (r_s_vld && (w_sc_i[OW] || w_sc_q[OW]));
        end
    end

    // Output register: load when free or being accepted; otherwise drop the result and flag overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_i     <= '0;
            o_q     <= '0;
            o_ovr   <= 1'b0;
        end else begin
            if (r_y_vld && (!o_valid || i_ready)) begin
                o_valid <= 1'b1;
                o_i     <= r_y_i;
                o_q     <= r_y_q;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            o_ovr <= (o_ovr && !i_flag_clr) || (r_y_vld && o_valid && !i_ready);
        end
    end

endmodule

// File: tb/tb_nco_mixer_decim.sv
// tb/tb_nco_mixer_decim.sv - self-checking bench for nco_mixer_decim
module tb_nco_mixer_decim;

    localparam int DW = 12, IW = 12, DECW = 12, OW = 16, ACCW = 36;

    logic                  clk = 1'b0;
    logic                  reset, ce, i_flag_clr, i_ready;
    logic signed [DW-1:0]  i_sample;
    logic signed [IW-1:0]  i_cos, i_sin;
    logic [DECW-1:0]       i_decim_m1;
    logic [5:0]            i_shift;
    logic                  o_valid, o_sat, o_ovr;
    logic signed [OW-1:0]  o_i, o_q;

    nco_mixer_decim #(.DW(DW), .IW(IW), .DECW(DECW), .OW(OW), .ACCW(ACCW)) dut (
        .clk(clk), .reset(reset), .ce(ce), .i_sample(i_sample), .i_cos(i_cos), .i_sin(i_sin),
        .i_decim_m1(i_decim_m1), .i_shift(i_shift), .i_flag_clr(i_flag_clr), .o_valid(o_valid),
        .i_ready(i_ready), .o_i(o_i), .o_q(o_q), .o_sat(o_sat), .o_ovr(o_ovr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int sample; int cosv; int sinv; int m1; int sh;
        int ei; int eq; int esat;
    } vec_t;
    vec_t vecs[8];

    longint exp_i[$];
    longint exp_q[$];
    int     f_cnt, f_len;
    longint f_si, f_sq;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ce = 1'b0; i_flag_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic set_in(input int s, input int c, input int n, input int m1, input int sh);
        i_sample = DW'(s); i_cos = IW'(c); i_sin = IW'(n);
        i_decim_m1 = DECW'(m1); i_shift = 6'(sh);
    endtask

    task automatic feed(input int n);
        ce = 1'b1;
        repeat (n) tick();
        ce = 1'b0;
    endtask

    task automatic wait_valid(input int limit, input string name);
        int k = 0;
        while (!o_valid && k < limit) begin
            tick();
            k++;
        end
        if (!o_valid) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=o_valid 0 required=o_valid 1", name);
        end
    endtask

    // Reference: floor division by 2^sh (optionally with +half), clamp to OW bits.
    function automatic longint ref_scale(input longint s, input int sh);
        longint y = s;
`ifdef MIXER_DECIM_ROUND_EN
        if (sh > 0) y = y + (longint'(1) <<< (sh - 1));
`endif
        y = y >>> sh;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    // Reference frame integrator fed with every accepted sample.
    task automatic model_accept();
        if (f_cnt == 0) begin
            f_len = int'(i_decim_m1);
            f_si = 0;
            f_sq = 0;
        end
        f_si += longint'(i_sample) * longint'(i_cos);
        f_sq -= longint'(i_sample) * longint'(i_sin);
        f_cnt++;
        if (f_cnt == f_len + 1) begin
            exp_i.push_back(ref_scale(f_si, int'(i_shift)));
            exp_q.push_back(ref_scale(f_sq, int'(i_shift)));
            f_cnt = 0;
        end
    endtask

    task automatic compare_out();
        longint ei, eq;
        if (o_valid && i_ready) begin
            if (exp_i.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rnd_extra actual=unexpected pair %0d/%0d required=none", o_i, o_q);
            end else begin
                ei = exp_i.pop_front();
                eq = exp_q.pop_front();
                check("rnd_i", o_i, ei);
                check("rnd_q", o_q, eq);
            end
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; i_flag_clr = 1'b0; i_ready = 1'b1;
        set_in(0, 0, 0, 0, 0);

        vecs[0] = '{1000, 1760, 0, 3, 8, 27500, 0, 0};
        vecs[1] = '{1000, 0, 1760, 3, 8, 0, -27500, 0};
        vecs[2] = '{2047, 2047, 0, 4095, 0, 32767, 0, 1};
        vecs[3] = '{-2048, 2047, 0, 4095, 0, -32768, 0, 1};
        vecs[6] = '{-500, 300, -200, 1, 4, -18750, -12500, 0};
`ifdef MIXER_DECIM_ROUND_EN
        vecs[4] = '{3, 1, 0, 0, 1, 2, 0, 0};
        vecs[5] = '{-3, 1, 0, 0, 1, -1, 0, 0};
        vecs[7] = '{5, 3, 1, 0, 2, 4, -1, 0};
`else
        vecs[4] = '{3, 1, 0, 0, 1, 1, 0, 0};
        vecs[5] = '{-3, 1, 0, 0, 1, -2, 0, 0};
        vecs[7] = '{5, 3, 1, 0, 2, 3, -2, 0};
`endif

        // Reset state
        do_reset();
        check("rst_valid", o_valid, 0);
        check("rst_i", o_i, 0);
        check("rst_q", o_q, 0);
        check("rst_sat", o_sat, 0);
        check("rst_ovr", o_ovr, 0);

        // Latency: valid appears exactly three edges after the last sample edge
        do_reset();
        set_in(1000, 1760, 0, 3, 8);
        feed(4);
        check("lat_e1", o_valid, 0);
        tick(); tick();
        check("lat_e2", o_valid, 0);
        tick();
        check("lat_e3", o_valid, 1);
        check("lat_i", o_i, 27500);

        // Table vectors, one frame each
        for (int v = 0; v < 8; v++) begin
            do_reset();
            i_ready = 1'b1;
            set_in(vecs[v].sample, vecs[v].cosv, vecs[v].sinv, vecs[v].m1, vecs[v].sh);
            feed(vecs[v].m1 + 1);
            wait_valid(10, $sformatf("vec%0d_wait", v));
            check($sformatf("vec%0d_i", v), o_i, vecs[v].ei);
            check($sformatf("vec%0d_q", v), o_q, vecs[v].eq);
            check($sformatf("vec%0d_sat", v), o_sat, vecs[v].esat);
        end

        // Sticky saturation: clear loses to a simultaneous set, then clears when quiet
        do_reset();
        set_in(2047, 2047, 0, 0, 0);
        ce = 1'b1; i_flag_clr = 1'b1;
        repeat (6) tick();
        check("sat_set_vs_clr", o_sat, 1);
        ce = 1'b0; i_flag_clr = 1'b0;
        repeat (5) tick();
        check("sat_hold", o_sat, 1);
        i_flag_clr = 1'b1;
        tick();
        i_flag_clr = 1'b0;
        check("sat_cleared", o_sat, 0);

        // Backpressure: first pair held, later results dropped with overrun
        do_reset();
        set_in(1, 1, 0, 0, 0);
        i_ready = 1'b0;
        ce = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            i_sample = DW'(k);
            tick();
        end
        ce = 1'b0;
        repeat (4) tick();
        check("bp_valid", o_valid, 1);
        check("bp_held_i", o_i, 1);
        check("bp_ovr", o_ovr, 1);
        tick();
        check("bp_stable_i", o_i, 1);
        i_flag_clr = 1'b1;
        tick();
        i_flag_clr = 1'b0;
        check("bp_ovr_clr", o_ovr, 0);
        i_sample = DW'(7);
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tick(); tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("bp_replace_valid", o_valid, 1);
        check("bp_replace_i", o_i, 7);
        check("bp_replace_ovr", o_ovr, 0);
        i_ready = 1'b1;
        tick();
        check("bp_drain_valid", o_valid, 0);

        // Reset mid-frame discards the partial frame
        do_reset();
        set_in(2000, 3, 0, 7, 0);
        feed(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_sample = DW'(1000);
        feed(8);
        wait_valid(10, "rstmid_wait");
        check("rstmid_i", o_i, 24000);
        check("rstmid_q", o_q, 0);

        // Randomized frames against the reference integrator
        do_reset();
        i_ready = 1'b1;
        f_cnt = 0; f_len = 0; f_si = 0; f_sq = 0;
        for (int r = 0; r < 8; r++) begin
            int m1, need;
            m1 = int'($urandom_range(0, 7));
            i_decim_m1 = DECW'(m1);
            i_shift = 6'($urandom_range(0, 20));
            need = (m1 + 1) * int'($urandom_range(2, 5));
            while (need > 0) begin
                ce = ($urandom_range(0, 3) != 0);
                i_sample = DW'($urandom);
                i_cos = IW'($urandom);
                i_sin = IW'($urandom);
                if (ce) begin
                    model_accept();
                    need--;
                end
                tick();
                compare_out();
            end
            ce = 1'b0;
            repeat (5) begin
                tick();
                compare_out();
            end
            check($sformatf("rnd%0d_pending", r), exp_i.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
